// File: rtl/tinycpu_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tinycpu_mon_pkg
// Purpose  : Shared constants for the tinycpu run monitor: default control
//            state codes, the jump opcode, and the bit offsets of each
//            register field inside a packed snapshot {rA,rB,rM,rP}.
// Revision : 1.0 - initial release
// ============================================================================
package tinycpu_mon_pkg;

  // Default control-state encodings of the tinycpu sequencer.
  localparam logic [5:0] IDLE_CODE_DEF = 6'b100000;
  localparam logic [5:0] EXEC_CODE_DEF = 6'b001000;

  // instr[7:6] value of the jump instruction.
  localparam logic [1:0] JMP_OP_DEF = 2'b11;

  // Snapshot layout: rA occupies the MSBs, rP the LSBs.
  function automatic int snap_ra_lsb(input int data_w);
    return 3 * data_w;
  endfunction

  function automatic int snap_rb_lsb(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic int snap_rm_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int snap_rp_lsb(input int data_w);
    return 0 * data_w;
  endfunction

endpackage : tinycpu_mon_pkg
`default_nettype wire

// File: rtl/mon_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mon_sync_fifo
// Purpose  : Single-clock FIFO with a register-file store and a head output
//            taken straight from the storage registers (no bypass: an entry
//            written on edge N is first visible after edge N).
// Ports    : clk, reset (async, active-low), clear (sync)
//            push/wdata - write request and data
//            pop        - read request (ignored when empty)
//            rdata      - head entry, zero while empty
//            valid      - FIFO not empty
//            drop       - pulse: push refused because full with no pop
// Revision : 1.0 - initial release
// ============================================================================
module mon_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the index bits match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic empty;
  logic full;
  logic do_pop;
  logic do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty && !clear;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop) && !clear;
  assign drop    = push && full && !do_pop && !clear;

  assign valid = !empty;
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule : mon_sync_fifo
`default_nettype wire

// File: rtl/cpu_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module   : cpu_trace_monitor
// Purpose  : Run monitor for the tinycpu family. Detects self-jump loops and
//            raises a sticky halt, counts cycles and retired instructions,
//            and queues a register snapshot per retired instruction.
// Ports    : clk, reset (async, active-low), clear (sync)
//            state_in, op_in, ra_in/rb_in/rm_in/rp_in - CPU taps
//            trace_valid/trace_ready/trace_data       - snapshot stream
//            trace_overflow - sticky, a snapshot was dropped
//            halt           - sticky, forever loop detected
//            cycle_count, retire_count - saturating counters
// Revision : 1.0 - initial release
// ============================================================================
module cpu_trace_monitor
  import tinycpu_mon_pkg::*;
#(
  parameter int                 DATA_W      = 8,
  parameter int                 STATE_W     = 6,
  parameter logic [STATE_W-1:0] IDLE_CODE   = STATE_W'(IDLE_CODE_DEF),
  parameter logic [STATE_W-1:0] EXEC_CODE   = STATE_W'(EXEC_CODE_DEF),
  parameter logic [1:0]         JMP_OP      = JMP_OP_DEF,
  parameter int                 LOOP_THRESH = 1,
  parameter int                 FIFO_DEPTH  = 8,
  parameter int                 CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [STATE_W-1:0]    state_in,
  input  logic [1:0]            op_in,
  input  logic [DATA_W-1:0]     ra_in,
  input  logic [DATA_W-1:0]     rb_in,
  input  logic [DATA_W-1:0]     rm_in,
  input  logic [DATA_W-1:0]     rp_in,
  output logic                  trace_valid,
  input  logic                  trace_ready,
  output logic [4*DATA_W-1:0]   trace_data,
  output logic                  trace_overflow,
  output logic                  halt,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [CNT_W-1:0]      retire_count
);

  localparam int SNAP_W = 4 * DATA_W;
  localparam int HIT_W  = (LOOP_THRESH > 1) ? $clog2(LOOP_THRESH + 1) : 1;

  // --------------------------------------------------------------------------
  // Event decode
  // --------------------------------------------------------------------------
  logic              retire;
  logic              is_exec;
  logic              loop_qual;
  logic [DATA_W-1:0] rp_minus1;

  assign retire    = (state_in == IDLE_CODE) && !halt;
  assign is_exec   = (state_in == EXEC_CODE);
  // rP already points past the jump, so a self-jump targets rP-1. The
  // subtraction wraps naturally at DATA_W bits.
  assign rp_minus1 = rp_in - DATA_W'(1);
  assign loop_qual = is_exec && (op_in == JMP_OP) && (rp_minus1 == rm_in);

  // --------------------------------------------------------------------------
  // Snapshot packing and buffer
  // --------------------------------------------------------------------------
  logic [SNAP_W-1:0] snap;
  logic              fifo_pop;
  logic              fifo_drop;

  assign snap[snap_ra_lsb(DATA_W) +: DATA_W] = ra_in;
  assign snap[snap_rb_lsb(DATA_W) +: DATA_W] = rb_in;
  assign snap[snap_rm_lsb(DATA_W) +: DATA_W] = rm_in;
  assign snap[snap_rp_lsb(DATA_W) +: DATA_W] = rp_in;

  assign fifo_pop = trace_valid && trace_ready;

  mon_sync_fifo #(
    .WIDTH (SNAP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_snap_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (retire),
    .wdata (snap),
    .pop   (fifo_pop),
    .rdata (trace_data),
    .valid (trace_valid),
    .drop  (fifo_drop)
  );

  // --------------------------------------------------------------------------
  // Loop detector
  // --------------------------------------------------------------------------
  logic [HIT_W-1:0] loop_hits;
  logic [HIT_W:0]   hits_inc;
  logic             hits_reach;

  assign hits_inc   = {1'b0, loop_hits} + (HIT_W+1)'(1);
  assign hits_reach = (hits_inc >= (HIT_W+1)'(LOOP_THRESH));

  // --------------------------------------------------------------------------
  // Counters, flags and loop state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count    <= '0;
      retire_count   <= '0;
      loop_hits      <= '0;
      halt           <= 1'b0;
      trace_overflow <= 1'b0;
    end else if (clear) begin
      cycle_count    <= '0;
      retire_count   <= '0;
      loop_hits      <= '0;
      halt           <= 1'b0;
      trace_overflow <= 1'b0;
    end else begin
      // Everything but the overflow flag freezes once halted; the FIFO can
      // still drain so a drop is impossible then anyway.
      if (!halt) begin
        if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
        if (retire && (retire_count != '1)) begin
          retire_count <= retire_count + CNT_W'(1);
        end
        if (loop_qual) begin
          // hits_inc never exceeds LOOP_THRESH here because halt sets on
          // reaching it, so the truncation cannot wrap.
          loop_hits <= hits_inc[HIT_W-1:0];
          if (hits_reach) halt <= 1'b1;
        end else if (is_exec) begin
          loop_hits <= '0;
        end
      end
      if (fifo_drop) trace_overflow <= 1'b1;
    end
  end

endmodule : cpu_trace_monitor
`default_nettype wire

// File: tb/tb_cpu_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_trace_monitor
// Purpose  : Self-checking bench for cpu_trace_monitor. A queue-based model
//            of the snapshot stream plus integer counters predicts every
//            output after each clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_trace_monitor;

  localparam int         DW     = 8;
  localparam int         DEPTH  = 8;
  localparam int         THRESH = 3;
  localparam logic [5:0] S_IDLE = 6'b100000;
  localparam logic [5:0] S_EXEC = 6'b001000;
  localparam logic [5:0] S_OTH  = 6'b000001;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic [5:0]    state_in = S_OTH;
  logic [1:0]    op_in = 2'b00;
  logic [DW-1:0] ra_in = '0, rb_in = '0, rm_in = '0, rp_in = '0;
  logic          trace_ready = 1'b0;
  logic          trace_valid;
  logic [31:0]   trace_data;
  logic          trace_overflow;
  logic          halt;
  logic [15:0]   cycle_count;
  logic [15:0]   retire_count;

  always #5 clk = ~clk;

  cpu_trace_monitor #(
    .DATA_W      (DW),
    .STATE_W     (6),
    .IDLE_CODE   (S_IDLE),
    .EXEC_CODE   (S_EXEC),
    .JMP_OP      (2'b11),
    .LOOP_THRESH (THRESH),
    .FIFO_DEPTH  (DEPTH),
    .CNT_W       (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .clear          (clear),
    .state_in       (state_in),
    .op_in          (op_in),
    .ra_in          (ra_in),
    .rb_in          (rb_in),
    .rm_in          (rm_in),
    .rp_in          (rp_in),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready),
    .trace_data     (trace_data),
    .trace_overflow (trace_overflow),
    .halt           (halt),
    .cycle_count    (cycle_count),
    .retire_count   (retire_count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [31:0] mq[$];
  int          m_cyc, m_ret, m_hits;
  bit          m_halt, m_ovf;

  task automatic m_zero();
    mq.delete();
    m_cyc = 0; m_ret = 0; m_hits = 0; m_halt = 0; m_ovf = 0;
  endtask

  // Apply one clock edge worth of behaviour using the inputs held at the edge.
  task automatic m_step();
    bit pop, push, was_full;
    if (!reset || clear) begin
      m_zero();
    end else begin
      pop      = (mq.size() > 0) && trace_ready;
      push     = (state_in == S_IDLE) && !m_halt;
      was_full = (mq.size() == DEPTH);
      if (pop) mq.delete(0);
      if (push) begin
        if (was_full && !pop) m_ovf = 1;
        else mq.push_back({ra_in, rb_in, rm_in, rp_in});
      end
      if (!m_halt) begin
        if (m_cyc < 65535) m_cyc++;
        if (push && m_ret < 65535) m_ret++;
        if (state_in == S_EXEC) begin
          if (op_in == 2'b11 && ((int'(rp_in) - 1) & 255) == int'(rm_in)) begin
            m_hits++;
            if (m_hits >= THRESH) m_halt = 1;
          end else begin
            m_hits = 0;
          end
        end
      end
    end
  endtask

  task automatic check(input string tag);
    logic [31:0] exp_d;
    bit          exp_v;
    exp_v = (mq.size() > 0);
    exp_d = exp_v ? mq[0] : 32'h0;
    total++;
    assert (trace_valid === exp_v) else begin
      bad++; $error("FAIL %s valid got=%b want=%b", tag, trace_valid, exp_v);
    end
    total++;
    assert (trace_data === exp_d) else begin
      bad++; $error("FAIL %s data got=%h want=%h", tag, trace_data, exp_d);
    end
    total++;
    assert (trace_overflow === m_ovf) else begin
      bad++; $error("FAIL %s overflow got=%b want=%b", tag, trace_overflow, m_ovf);
    end
    total++;
    assert (halt === m_halt) else begin
      bad++; $error("FAIL %s halt got=%b want=%b", tag, halt, m_halt);
    end
    total++;
    assert (cycle_count === 16'(m_cyc)) else begin
      bad++; $error("FAIL %s cycles got=%0d want=%0d", tag, cycle_count, m_cyc);
    end
    total++;
    assert (retire_count === 16'(m_ret)) else begin
      bad++; $error("FAIL %s retires got=%0d want=%0d", tag, retire_count, m_ret);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    m_step();
    #1;
    check(tag);
  endtask

  task automatic drive(input logic [5:0] st, input logic [1:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] m, input logic [7:0] p,
                       input logic rdy, input logic clr, input string tag);
    state_in = st; op_in = op;
    ra_in = a; rb_in = b; rm_in = m; rp_in = p;
    trace_ready = rdy; clear = clr;
    tick(tag);
  endtask

  initial begin
    m_zero();
    // Power-on reset.
    #1;
    check("por");
    tick("por_hold");
    tick("por_hold2");
    #2 reset = 1'b1;

    // Retire stream drained on the fly.
    for (int i = 0; i < 5; i++)
      drive(S_IDLE, 2'b00, 8'(i+1), 8'(i+2), 8'(i+3), 8'(i+4), 1'b1, 1'b0, "stream");
    drive(S_OTH, 2'b00, 0, 0, 0, 0, 1'b1, 1'b0, "stream_tail");

    // Overflow: ten retires into a stalled FIFO, then drain.
    drive(S_OTH, 2'b00, 0, 0, 0, 0, 1'b0, 1'b1, "clr1");
    for (int i = 0; i < 10; i++)
      drive(S_IDLE, 2'b01, 8'(16*i), 8'(16*i+1), 8'(16*i+2), 8'(16*i+3), 1'b0, 1'b0, "ovf_fill");
    for (int i = 0; i < 9; i++)
      drive(S_OTH, 2'b00, 0, 0, 0, 0, 1'b1, 1'b0, "ovf_drain");

    // Full FIFO with simultaneous push and pop.
    drive(S_OTH, 2'b00, 0, 0, 0, 0, 1'b0, 1'b1, "clr2");
    for (int i = 0; i < 8; i++)
      drive(S_IDLE, 2'b00, 8'hA0, 8'(i), 8'h00, 8'h00, 1'b0, 1'b0, "full_fill");
    drive(S_IDLE, 2'b00, 8'hBE, 8'hEF, 8'h55, 8'h66, 1'b1, 1'b0, "full_pushpop");
    for (int i = 0; i < 9; i++)
      drive(S_OTH, 2'b00, 0, 0, 0, 0, 1'b1, 1'b0, "full_drain");

    // Asynchronous reset between edges with three entries held.
    for (int i = 0; i < 3; i++)
      drive(S_IDLE, 2'b00, 8'h33, 8'(i), 8'h00, 8'h00, 1'b0, 1'b0, "pre_rst");
    #2 reset = 1'b0;
    #1 m_zero();
    check("async_rst");
    tick("rst_hold");
    #2 reset = 1'b1;
    drive(S_OTH, 2'b00, 0, 0, 0, 0, 1'b1, 1'b0, "post_rst");

    // Loop threshold: three self-jumps with wrap-around target, IDLE between.
    drive(S_OTH, 2'b00, 0, 0, 0, 0, 1'b1, 1'b1, "clr3");
    for (int k = 0; k < 3; k++) begin
      drive(S_EXEC, 2'b11, 8'h11, 8'h22, 8'hFF, 8'h00, 1'b1, 1'b0, "loop_exec");
      drive(S_IDLE, 2'b11, 8'h11, 8'h22, 8'hFF, 8'h00, 1'b1, 1'b0, "loop_idle");
    end
    for (int k = 0; k < 4; k++)
      drive(S_IDLE, 2'b00, 8'h44, 8'h44, 8'h44, 8'h44, 1'b1, 1'b0, "halted");

    // Loop counter reset by an intervening non-jump execute.
    drive(S_OTH, 2'b00, 0, 0, 0, 0, 1'b1, 1'b1, "clr4");
    drive(S_EXEC, 2'b11, 0, 0, 8'h40, 8'h41, 1'b1, 1'b0, "lr_jmp1");
    drive(S_IDLE, 2'b00, 1, 2, 8'h40, 8'h41, 1'b1, 1'b0, "lr_idle");
    drive(S_EXEC, 2'b00, 0, 0, 8'h40, 8'h41, 1'b1, 1'b0, "lr_nonjmp");
    drive(S_EXEC, 2'b11, 0, 0, 8'h40, 8'h41, 1'b1, 1'b0, "lr_jmp2");
    drive(S_EXEC, 2'b11, 0, 0, 8'h40, 8'h41, 1'b1, 1'b0, "lr_jmp3");
    drive(S_EXEC, 2'b11, 0, 0, 8'h40, 8'h42, 1'b1, 1'b0, "lr_jmp_else");
    drive(S_OTH, 2'b00, 0, 0, 0, 0, 1'b0, 1'b1, "clr5");

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      int          sel;
      logic [5:0]  st;
      logic [7:0]  m, p;
      sel = int'($urandom_range(0, 9));
      if (sel < 4)      st = S_IDLE;
      else if (sel < 7) st = S_EXEC;
      else              st = 6'($urandom);
      m = 8'($urandom);
      p = ($urandom_range(0, 3) != 0) ? m + 8'd1 : 8'($urandom);
      drive(st, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), m, p,
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 80) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cpu_trace_monitor
`default_nettype wire

// File: doc/cpu_trace_monitor.md
Name: cpu_trace_monitor

Overview:
- Synthesizable, parametrised run monitor for the tinycpu family; sits beside the CPU inside sim_env and taps the control state, the opcode field and the four architectural registers.
- Detects self-jump ("forever") loops with a configurable repeat threshold and raises a sticky halt request.
- Counts cycles and retired instructions.
- Buffers a register snapshot per retired instruction in a FIFO that a bench or debug port drains with a valid/ready handshake.

Parameters:
DATA_W, 8, width of each CPU register (rA, rB, rM, rP)
STATE_W, 6, width of the CPU control state vector
IDLE_CODE, 6'b100000, state encoding marking instruction boundary/retire
EXEC_CODE, 6'b001000, state encoding of the execute state
JMP_OP, 2'b11, opcode (instr[7:6]) of the jump instruction
LOOP_THRESH, 1, consecutive self-jump executions required to halt (>=1)
FIFO_DEPTH, 8, snapshot FIFO entries (power of two, >=2)
CNT_W, 16, width of cycle and retire counters

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
clear  in  1  synchronous clear of counters, flags and FIFO
state_in  in  STATE_W  CPU control state
op_in  in  2  instr[7:6] of the current instruction
ra_in, rb_in, rm_in, rp_in  in  DATA_W each  register outputs
trace_valid  out  1  FIFO head valid
trace_ready  in  1  consumer accepts head
trace_data  out  4*DATA_W  head snapshot {rA,rB,rM,rP}, rA in MSBs
trace_overflow  out  1  sticky: snapshot dropped on full FIFO
halt  out  1  sticky: forever loop detected
cycle_count  out  CNT_W  cycles since reset/clear (while not halted)
retire_count  out  CNT_W  IDLE samples since reset/clear (while not halted)

Behaviour:
- Reset (reset=0, async): all outputs 0, FIFO empty, loop counter 0. Monitor starts sampling on the first rising edge after reset deasserts.
- clear=1: same effect as reset on the next edge. It overrides every other event in that cycle, including push and pop.
- Retire event: state_in==IDLE_CODE && !halt.
  - Increments retire_count, saturating at all-ones.
  - Pushes {ra_in,rb_in,rm_in,rp_in} into the FIFO.
- cycle_count increments every cycle while !halt, saturating at all-ones.
- Loop qualifier: state_in==EXEC_CODE && op_in==JMP_OP && (rp_in-1)==rm_in.
  - Subtraction is modulo 2^DATA_W, so rp_in=0 matches rm_in=all-ones.
  - Qualifier sampled: loop_hits increments.
  - Any other EXEC_CODE sample (non-jump, or a jump elsewhere): loop_hits resets to 0.
  - Non-EXEC states leave loop_hits unchanged.
  - On the edge where loop_hits would reach LOOP_THRESH, halt is registered to 1 (one-cycle latency from the qualifying sample).
- After halt:
  - Counters freeze; no further pushes.
  - FIFO continues to drain.
  - halt stays 1 until reset or clear.
- FIFO:
  - Pop occurs when trace_valid && trace_ready.
  - A snapshot pushed at edge N is visible at trace_valid/trace_data after edge N (one-cycle latency) if the FIFO was empty.
  - trace_data is stable while trace_valid && !trace_ready.
  - Full FIFO with push and pop in the same cycle: both succeed, count unchanged, no overflow.
  - Full FIFO with push and no pop: snapshot dropped, trace_overflow set (sticky), existing contents intact.
  - Empty FIFO with push and trace_ready=1: the new entry is not popped that cycle (no bypass).
  - Pointers wrap modulo FIFO_DEPTH; an extra occupancy bit distinguishes full from empty.
- Inputs are assumed synchronous to clk; no synchronisers are included.

Decomposition:
- Package tinycpu_mon_pkg holds:
  - default IDLE/EXEC state codes
  - JMP opcode constant
  - snapshot field offsets (RA/RB/RM/RP slice positions as functions of DATA_W)
- One sub-module: mon_sync_fifo (parametrised width/depth, push/pop, full/empty, registered head). It is instantiated once for the snapshot buffer.
- Loop detector and counters stay in the top module.

Test Plan:
- Reset mid-run: assert reset=0 asynchronously between edges while FIFO holds 3 entries -> all outputs 0 immediately; FIFO empty after release.
- Retire stream, trace_ready=1: 5 IDLE samples with rA..rP=01,02,03,04 incrementing -> 5 snapshots in order (first 0x01020304); retire_count=5; no overflow.
- Overflow: FIFO_DEPTH=8, trace_ready=0, 10 retires -> trace_valid=1, 8 entries held, trace_overflow=1 after the 9th; draining returns the first 8 snapshots in order.
- Full with simultaneous push/pop: full FIFO, trace_ready=1 with a retire the same cycle -> trace_overflow stays 0 and the new snapshot appears last.
- Loop threshold: LOOP_THRESH=3, EXEC with op=11, rM=0xFF, rP=0x00 three times separated by IDLE -> halt=1 one cycle after the third sample; counters frozen.
- Loop reset: LOOP_THRESH=2, self-jump, then EXEC op=00, then self-jump -> halt stays 0; clear=1 afterward zeroes both counters and FIFO.
